multdiv_exec_unit: RTL and testbench

//  Execute-stage multi-cycle unit for mul/div. Consumes the decoded opcode and ALU op from D/X.

---
 rtl/multdiv_exec_unit_pkg.sv | 11 +
 rtl/multdiv_exec_unit_if.sv | 23 ++
 rtl/multdiv_exec_unit_iter_engine.sv | 43 ++++
 rtl/multdiv_exec_unit.sv | 79 +++++++
 tb/tb_multdiv_exec_unit.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/multdiv_exec_unit_pkg.sv
// multdiv_exec_unit_pkg: shared opcodes, status codes and FSM states for the mul/div execute unit.
package multdiv_exec_unit_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ITERS = 32;
   localparam logic [4:0] OPC_RTYPE = 5'b00000;
   localparam logic [4:0] ALUOP_MUL = 5'b00110;
   localparam logic [4:0] ALUOP_DIV = 5'b00111;
   localparam int RSTATUS_MUL = 4;
   localparam int RSTATUS_DIV = 5;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/multdiv_exec_unit_if.sv
// multdiv_exec_unit_if: D/X issue bundle and X/M result bundle of the mul/div execute unit.
interface multdiv_exec_unit_if #(parameter int DATA_W = 32);
   logic              dx_valid;
   logic [4:0]        dx_opcode;
   logic [4:0]        dx_alu_op;
   logic [4:0]        dx_rd;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic              stall;
   logic              result_valid;
   logic [DATA_W-1:0] result;
   logic [4:0]        result_rd;
   logic              exception;
   logic [DATA_W-1:0] rstatus_value;
   modport master (
      output dx_valid, dx_opcode, dx_alu_op, dx_rd, operand_a, operand_b,
      input  stall, result_valid, result, result_rd, exception, rstatus_value
   );
   modport slave (
      input  dx_valid, dx_opcode, dx_alu_op, dx_rd, operand_a, operand_b,
      output stall, result_valid, result, result_rd, exception, rstatus_value
   );
endinterface

// File: rtl/multdiv_exec_unit_iter_engine.sv
// multdiv_exec_unit_iter_engine: radix-2 shift-add multiply / non-restoring divide on operand magnitudes.
module multdiv_exec_unit_iter_engine #(parameter int W = 32) (
   input  logic         clock,
   input  logic         start,
   input  logic         step,
   input  logic         is_div,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result,
   output logic         ovf
);
   logic [W:0]     hi, r_sh, sum, hi_nx;
   logic [W-1:0]   lo, mop, lo_nx, abs_a, abs_b, quo;
   logic [2*W-1:0] prod, sprod;
   logic           neg, div_q;
   // result/ovf reflect the state after the current step, so the last step's outcome is visible in-cycle
   always_comb begin
      abs_a = a[W-1] ? -a : a;
      abs_b = b[W-1] ? -b : b;
      r_sh  = {hi[W-1:0], lo[W-1]};
      sum   = div_q ? (hi[W] ? r_sh + {1'b0, mop} : r_sh - {1'b0, mop})
                    : hi + (lo[0] ? {1'b0, mop} : '0);
      hi_nx = div_q ? sum : {1'b0, sum[W:1]};
      lo_nx = div_q ? {lo[W-2:0], ~sum[W]} : {sum[0], lo[W-1:1]};
      prod  = {hi_nx[W-1:0], lo_nx};
      sprod = neg ? -prod : prod;
      quo   = neg ? -lo_nx : lo_nx;
      result = div_q ? quo : sprod[W-1:0];
      ovf    = div_q ? (~neg & lo_nx[W-1]) : ~(&sprod[2*W-1:W-1] | ~|sprod[2*W-1:W-1]);
   end
   always_ff @(posedge clock) begin
      if (start) begin
         hi    <= '0;
         lo    <= is_div ? abs_a : abs_b;
         mop   <= is_div ? abs_b : abs_a;
         neg   <= a[W-1] ^ b[W-1];
         div_q <= is_div;
      end else if (step) begin
         hi <= hi_nx;
         lo <= lo_nx;
      end
   end
endmodule

// File: rtl/multdiv_exec_unit.sv
// multdiv_exec_unit: stalls the pipeline while an iterative mul/div runs, then pulses one result.
module multdiv_exec_unit
   import multdiv_exec_unit_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ITERS      = DEF_ITERS,
   parameter int MUL_STATUS = RSTATUS_MUL,
   parameter int DIV_STATUS = RSTATUS_DIV
) (
   input logic clock,
   input logic reset,
   multdiv_exec_unit_if.slave io
);
   localparam int CW = $clog2(ITERS);
   state_t            state;
   logic [CW-1:0]     cnt;
   logic [4:0]        rd_q;
   logic              op_div, is_mul, is_div, issue, div0, last, eng_ovf;
   logic [DATA_W-1:0] eng_res;
   always_comb begin
      is_mul   = io.dx_alu_op == ALUOP_MUL;
      is_div   = io.dx_alu_op == ALUOP_DIV;
      issue    = io.dx_valid && io.dx_opcode == OPC_RTYPE && (is_mul || is_div) && state == IDLE;
      div0     = is_div && io.operand_b == '0;
      last     = cnt == CW'(ITERS - 1);
      io.stall = issue || state == BUSY;
   end
   multdiv_exec_unit_iter_engine #(.W(DATA_W)) u_engine (
      .clock  (clock),
      .start  (issue && !div0),
      .step   (state == BUSY),
      .is_div (is_div),
      .a      (io.operand_a),
      .b      (io.operand_b),
      .result (eng_res),
      .ovf    (eng_ovf)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         cnt              <= '0;
         io.result_valid  <= 1'b0;
         io.result        <= '0;
         io.result_rd     <= '0;
         io.exception     <= 1'b0;
         io.rstatus_value <= '0;
      end else begin
         io.result_valid <= 1'b0;
         case (state)
            IDLE: if (issue) begin
               cnt    <= '0;
               rd_q   <= io.dx_rd;
               op_div <= is_div;
               state  <= div0 ? DONE : BUSY;
               // divide-by-zero is resolved at issue and never enters the engine
               if (div0) begin
                  io.result_valid  <= 1'b1;
                  io.result        <= '0;
                  io.result_rd     <= io.dx_rd;
                  io.exception     <= 1'b1;
                  io.rstatus_value <= DATA_W'(DIV_STATUS);
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (last) begin
                  state            <= DONE;
                  io.result_valid  <= 1'b1;
                  io.result        <= eng_res;
                  io.result_rd     <= rd_q;
                  io.exception     <= eng_ovf;
                  io.rstatus_value <= eng_ovf ? DATA_W'(op_div ? DIV_STATUS : MUL_STATUS) : '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multdiv_exec_unit.sv
// tb_multdiv_exec_unit: scoreboarded bench for the mul/div execute unit, results checked on each pulse.
module tb_multdiv_exec_unit;
   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        exc;
      logic [31:0] rst;
   } exp_t;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int n_tests = 0, n_fail = 0, cyc = 0, pulses = 0, last_pulse = 0, prev_pulse = 0, p0 = 0;
   exp_t sb[$];
   multdiv_exec_unit_if #(.DATA_W(32)) io();
   multdiv_exec_unit dut (.clock(clock), .reset(reset), .io(io));
   always #5 clock = ~clock;
   always @(posedge clock) cyc++;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   function automatic exp_t model(input logic div, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd);
      logic signed [63:0] p;
      exp_t e;
      e.rd = rd;
      if (!div) begin
         p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         e.res = p[31:0];
         e.exc = !(p[63:31] == '0 || p[63:31] == '1);
      end else if (b == 0) begin
         e.res = 0;
         e.exc = 1;
      end else if (a == 32'h80000000 && b == 32'hffffffff) begin
         e.res = 32'h80000000;
         e.exc = 1;
      end else begin
         e.res = 32'($signed(a) / $signed(b));
         e.exc = 0;
      end
      e.rst = e.exc ? (div ? 32'd5 : 32'd4) : 32'd0;
      return e;
   endfunction
   always @(negedge clock) begin
      exp_t e;
      if (!reset && io.result_valid) begin
         pulses++;
         prev_pulse = last_pulse;
         last_pulse = cyc;
         chk("sb_pending", 64'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("result", io.result, e.res);
            chk("result_rd", io.result_rd, e.rd);
            chk("exception", io.exception, e.exc);
            chk("rstatus", io.rstatus_value, e.rst);
         end
      end
   end
   task automatic issue(input logic div, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      int lat, t_lat;
      @(posedge clock); #1;
      io.dx_valid  = 1'b1;
      io.dx_opcode = 5'b00000;
      io.dx_alu_op = div ? 5'b00111 : 5'b00110;
      io.dx_rd     = rd;
      io.operand_a = a;
      io.operand_b = b;
      sb.push_back(model(div, a, b, rd));
      t_lat = (div && b == 0) ? 1 : 33;
      @(negedge clock);
      chk("stall_issue", io.stall, 1);
      lat = 0;
      while (io.stall && lat < 60) begin
         @(negedge clock);
         lat++;
      end
      chk("latency", lat, t_lat);
      chk("valid_done", io.result_valid, 1);
   endtask
   task automatic bubble();
      @(posedge clock); #1;
      io.dx_valid  = 1'b0;
      io.dx_alu_op = 5'b00000;
   endtask
   initial begin
      io.dx_valid = 0; io.dx_opcode = 0; io.dx_alu_op = 0; io.dx_rd = 0;
      io.operand_a = 0; io.operand_b = 0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_stall", io.stall, 0);
      chk("rst_valid", io.result_valid, 0);
      chk("rst_result", io.result, 0);
      chk("rst_rd", io.result_rd, 0);
      chk("rst_exc", io.exception, 0);
      chk("rst_rstatus", io.rstatus_value, 0);
      issue(0, 32'd7, -32'sd3, 5'd5);
      issue(0, 32'h00010000, 32'h00010000, 5'd6);
      issue(1, -32'sd7, 32'd2, 5'd7);
      issue(1, 32'd5, 32'd0, 5'd8);
      issue(1, 32'h80000000, 32'hffffffff, 5'd9);
      bubble();
      p0 = pulses;
      issue(0, 32'd123, -32'sd456, 5'd10);
      issue(1, 32'd100000, -32'sd7, 5'd11);
      bubble();
      chk("b2b_pulses", pulses - p0, 2);
      chk("b2b_gap", last_pulse - prev_pulse, 34);
      for (int i = 0; i < 8; i++)
         issue(1'($urandom_range(0, 1)), $urandom,
               ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 70000)) - 32'd35000,
               5'($urandom_range(1, 31)));
      bubble();
      p0 = pulses;
      io.dx_alu_op = 5'b00110;
      @(negedge clock);
      chk("no_issue_invalid", io.stall, 0);
      @(posedge clock); #1;
      io.dx_valid  = 1'b1;
      io.dx_opcode = 5'b00100;
      @(negedge clock);
      chk("no_issue_opcode", io.stall, 0);
      @(posedge clock); #1;
      io.dx_opcode = 5'b00000;
      io.operand_a = 32'd3;
      io.operand_b = 32'd4;
      io.dx_rd     = 5'd12;
      repeat (10) @(negedge clock);
      chk("mid_busy_stall", io.stall, 1);
      @(posedge clock); #1;
      reset = 1'b1;
      io.dx_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("reset_stall", io.stall, 0);
      chk("reset_valid", io.result_valid, 0);
      chk("reset_result", io.result, 0);
      chk("reset_rd", io.result_rd, 0);
      chk("reset_exc", io.exception, 0);
      repeat (40) @(negedge clock);
      chk("reset_no_pulse", pulses - p0, 0);
      @(posedge clock); #1;
      io.dx_valid  = 1'b1;
      io.dx_alu_op = 5'b00000;
      repeat (3) begin
         @(negedge clock);
         chk("add_no_stall", io.stall, 0);
      end
      issue(0, -32'sd5, -32'sd6, 5'd13);
      bubble();
      repeat (2) @(negedge clock);
      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
